uncache_store_buffer: RTL and testbench
=======================================

Name: uncache_store_buffer

Overview:
- Posted-write buffer for uncached (device/MMIO) data accesses. Sits between the core's uncached data port and the uncached channel of the AXI controller.
- Uncached stores are queued in a small FIFO so the core continues without waiting for the AXI write response.
- Uncached loads are strictly ordered behind all queued stores, then issued as single-beat reads.

Parameters:
DEPTH  4  store FIFO entries; power of two, >=2
ADDR_WD  32  address width
DATA_WD  32  data width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
conf_en  in  1  uncached access request from core (held while stallreq=1)
conf_we  in  4  byte write strobes; 0 = load
conf_addr  in  ADDR_WD  physical address (post-MMU)
conf_wdata  in  DATA_WD  store data
conf_rdata  out  DATA_WD  load data, registered
stallreq  out  1  stall request to core pipeline
axi_en  out  1  request to AXI controller uncached channel
axi_wsel  out  4  byte strobes to AXI controller; 0 = read
axi_addr  out  ADDR_WD  request address
axi_wdata  out  DATA_WD  request write data
reload  in  1  single-cycle completion pulse from AXI controller
axi_rdata  in  DATA_WD  read data, valid when reload=1

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port reset.
- State: FIFO of {we, addr, wdata}. wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH. count ranges 0..DEPTH. FSM states: IDLE, WRITE, READ, DONE.
- Reset (async, any state): state=IDLE, pointers=0, count=0, all FIFO contents discarded. Outputs: axi_en=0, axi_wsel=0, axi_addr=0, axi_wdata=0, conf_rdata=0. stallreq=0 once conf_en=0.
- Store enqueue (conf_en=1, conf_we!=0):
  - count<DEPTH: entry written at the clock edge, stallreq=0 in that cycle (combinational). Zero-latency accept.
  - count==DEPTH: stallreq=1. The store is accepted in the first cycle where count<DEPTH at the start of the cycle.
  - A pop in the same cycle does not free the slot early.
- Load (conf_en=1, conf_we==0):
  - stallreq=1 while count>0 or state!=DONE.
  - Load is issued only in IDLE with count==0 (stores drain first; strict program order).
- IDLE:
  - count>0 -> WRITE (drain has priority over a load).
  - else if a load is pending -> READ.
  - reload in IDLE is ignored.
- WRITE:
  - axi_en=1; axi_wsel/axi_addr/axi_wdata = FIFO head, all registered and stable until reload.
  - On reload: pop (rd_ptr+1, count-1), axi_en=0 next cycle, -> IDLE.
  - An enqueue in the same cycle as a pop leaves count unchanged.
- READ:
  - axi_en=1, axi_wsel=0, axi_addr=conf_addr (latched on entry), axi_wdata=0.
  - On reload: conf_rdata<=axi_rdata, -> DONE.
- DONE:
  - stallreq=0 for exactly this cycle so the core advances; -> IDLE.
  - conf_rdata holds its value until the next load completes.
- axi_en is never asserted in the cycle immediately after reload. There is a minimum one-cycle gap between requests.
- conf_en=0 never stalls, including while draining.
- A store presented while a load is in flight is not possible, since the core is stalled.

Test Plan:
- Reset then 3 stores (addr 0xBFAF_F000/4/8, data 0x11/0x22/0x33, we=0xF) on consecutive cycles, reload 2 cycles after each axi_en -> stallreq stays 0; AXI sees three writes in order; count returns to 0.
- 5 back-to-back stores with reload held off -> stallreq=0 for the first 4 and =1 on the 5th. The 5th is accepted the cycle after the first reload; order is preserved across pointer wrap.
- 2 stores queued, then load from 0xBFAF_F010 with axi_rdata=0xDEAD_BEEF -> both writes are issued before the read (axi_wsel=0). stallreq drops for exactly one cycle (DONE) and conf_rdata=0xDEAD_BEEF.
- Store accepted in the same cycle as a WRITE reload with count=2 -> count stays 2; next head is the older entry.
- Reset asserted mid-WRITE with count=3 -> axi_en=0 and count=0 asynchronously; no further AXI requests after release.
- Byte store we=0x2, addr 0xBFD0_F001, data 0x0000_AB00 -> axi_wsel=0x2 and axi_wdata=0x0000_AB00 exactly as enqueued.

Source files
------------

// File: rtl/uncache_store_buffer.sv
// Posted-write buffer for uncached (MMIO) accesses: stores queue and retire in the background,
// loads wait until all older stores have drained. States: IDLE pick next op | WRITE head store on AXI | READ load on AXI | DONE release core
module uncache_store_buffer #(
  parameter int DEPTH   = 4,
  parameter int ADDR_WD = 32,
  parameter int DATA_WD = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               conf_en,
  input  logic [3:0]         conf_we,
  input  logic [ADDR_WD-1:0] conf_addr,
  input  logic [DATA_WD-1:0] conf_wdata,
  output logic [DATA_WD-1:0] conf_rdata,
  output logic               stallreq,
  output logic               axi_en,
  output logic [3:0]         axi_wsel,
  output logic [ADDR_WD-1:0] axi_addr,
  output logic [DATA_WD-1:0] axi_wdata,
  input  logic               reload,
  input  logic [DATA_WD-1:0] axi_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_e;

  state_e             state_q, state_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;

  logic [3:0]         fifo_we_q    [DEPTH];
  logic [ADDR_WD-1:0] fifo_addr_q  [DEPTH];
  logic [DATA_WD-1:0] fifo_wdata_q [DEPTH];

  logic               axi_en_q, axi_en_d;
  logic [3:0]         axi_wsel_q, axi_wsel_d;
  logic [ADDR_WD-1:0] axi_addr_q, axi_addr_d;
  logic [DATA_WD-1:0] axi_wdata_q, axi_wdata_d;
  logic [DATA_WD-1:0] conf_rdata_q, conf_rdata_d;

  logic is_store, is_load, full, push, pop;

  assign is_store = conf_en && (conf_we != 4'b0000);
  assign is_load  = conf_en && (conf_we == 4'b0000);
  // Fullness uses the start-of-cycle count, so a same-cycle pop never frees a slot early.
  assign full     = (count_q == CW'(DEPTH));
  assign push     = is_store && !full;
  assign pop      = (state_q == WRITE) && reload;

  assign stallreq = (is_store && full) ||
                    (is_load && ((count_q != '0) || (state_q != DONE)));

  assign axi_en     = axi_en_q;
  assign axi_wsel   = axi_wsel_q;
  assign axi_addr   = axi_addr_q;
  assign axi_wdata  = axi_wdata_q;
  assign conf_rdata = conf_rdata_q;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    axi_en_d     = axi_en_q;
    axi_wsel_d   = axi_wsel_q;
    axi_addr_d   = axi_addr_q;
    axi_wdata_d  = axi_wdata_q;
    conf_rdata_d = conf_rdata_q;
    case (state_q)
      IDLE: begin
        // Draining wins over a pending load to keep program order.
        if (count_q != '0) begin
          state_d     = WRITE;
          axi_en_d    = 1'b1;
          axi_wsel_d  = fifo_we_q[rd_ptr_q];
          axi_addr_d  = fifo_addr_q[rd_ptr_q];
          axi_wdata_d = fifo_wdata_q[rd_ptr_q];
        end else if (is_load) begin
          state_d     = READ;
          axi_en_d    = 1'b1;
          axi_wsel_d  = 4'b0000;
          axi_addr_d  = conf_addr;
          axi_wdata_d = '0;
        end
      end
      WRITE: begin
        if (reload) begin
          state_d  = IDLE;
          axi_en_d = 1'b0;
        end
      end
      READ: begin
        if (reload) begin
          state_d      = DONE;
          axi_en_d     = 1'b0;
          conf_rdata_d = axi_rdata;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        axi_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      axi_en_q     <= 1'b0;
      axi_wsel_q   <= 4'b0000;
      axi_addr_q   <= '0;
      axi_wdata_q  <= '0;
      conf_rdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_we_q[i]    <= 4'b0000;
        fifo_addr_q[i]  <= '0;
        fifo_wdata_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      axi_en_q     <= axi_en_d;
      axi_wsel_q   <= axi_wsel_d;
      axi_addr_q   <= axi_addr_d;
      axi_wdata_q  <= axi_wdata_d;
      conf_rdata_q <= conf_rdata_d;
      if (push) begin
        fifo_we_q[wr_ptr_q]    <= conf_we;
        fifo_addr_q[wr_ptr_q]  <= conf_addr;
        fifo_wdata_q[wr_ptr_q] <= conf_wdata;
      end
    end
  end

endmodule

// File: tb/tb_uncache_store_buffer.sv
// Bench for uncache_store_buffer: store vector table, AXI responder, and a scoreboard of
// expected AXI requests in program order; hand sequences cover load ordering, pop+push, and reset.
module tb_uncache_store_buffer;

  typedef struct {
    logic [3:0]  wsel;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  typedef struct {
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        resp_en;
    logic        drain_first;
    logic        exp_stall;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        conf_en;
  logic [3:0]  conf_we;
  logic [31:0] conf_addr;
  logic [31:0] conf_wdata;
  logic [31:0] conf_rdata;
  logic        stallreq;
  logic        axi_en;
  logic [3:0]  axi_wsel;
  logic [31:0] axi_addr;
  logic [31:0] axi_wdata;
  logic        reload;
  logic [31:0] axi_rdata;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic resp_en = 1'b0;
  logic [31:0] rd_data = '0;
  logic rl_edge = 1'b0;
  int   req_seen = 0;
  vec_t vecs[9];

  uncache_store_buffer #(.DEPTH(4), .ADDR_WD(32), .DATA_WD(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .conf_en    (conf_en),
    .conf_we    (conf_we),
    .conf_addr  (conf_addr),
    .conf_wdata (conf_wdata),
    .conf_rdata (conf_rdata),
    .stallreq   (stallreq),
    .axi_en     (axi_en),
    .axi_wsel   (axi_wsel),
    .axi_addr   (axi_addr),
    .axi_wdata  (axi_wdata),
    .reload     (reload),
    .axi_rdata  (axi_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // AXI responder: pulses reload on the 2nd cycle of each request while enabled.
  initial begin
    int age;
    age = 0;
    reload = 1'b0;
    axi_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (resp_en) begin
        reload = 1'b0;
        if (axi_en) begin
          age++;
          if (age >= 2) begin
            reload = 1'b1;
            axi_rdata = rd_data;
            age = 0;
          end
        end else begin
          age = 0;
        end
      end else begin
        age = 0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      rl_edge = reload;
    end
  end

  // Request monitor: pops the scoreboard at each new request, checks fields stay stable.
  initial begin
    logic prev_en;
    exp_t cur;
    prev_en = 1'b0;
    cur.wsel = '0; cur.addr = '0; cur.wdata = '0;
    forever begin
      @(negedge clk);
      if (rl_edge) chk("gap_after_reload", axi_en, 0);
      if (axi_en && !prev_en) begin
        req_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_req", axi_en, 0);
          cur.wsel = axi_wsel; cur.addr = axi_addr; cur.wdata = axi_wdata;
        end else begin
          cur = exp_q.pop_front();
          chk("req_wsel", axi_wsel, cur.wsel);
          chk("req_addr", axi_addr, cur.addr);
          chk("req_wdata", axi_wdata, cur.wdata);
        end
      end else if (axi_en && prev_en) begin
        chk("stable_wsel", axi_wsel, cur.wsel);
        chk("stable_addr", axi_addr, cur.addr);
        chk("stable_wdata", axi_wdata, cur.wdata);
      end
      prev_en = axi_en;
    end
  end

  task automatic apply_store(input logic [3:0] we, input logic [31:0] addr,
                             input logic [31:0] data, input logic exp_stall, input string nm);
    exp_t e;
    int   n;
    conf_en = 1'b1; conf_we = we; conf_addr = addr; conf_wdata = data;
    e.wsel = we; e.addr = addr; e.wdata = data;
    exp_q.push_back(e);
    @(negedge clk);
    chk({nm, "_stall"}, stallreq, exp_stall);
    if (stallreq) begin
      resp_en = 1'b1;
      n = 0;
      while (stallreq && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (stallreq) chk({nm, "_accept_wait"}, stallreq, 0);
      else chk({nm, "_accept_after_reload"}, rl_edge, 1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] prev, input string nm);
    exp_t e;
    int   n;
    e.wsel = 4'b0000; e.addr = addr; e.wdata = '0;
    exp_q.push_back(e);
    rd_data = data;
    conf_en = 1'b1; conf_we = 4'b0000; conf_addr = addr; conf_wdata = '0;
    @(negedge clk);
    chk({nm, "_stall_first"}, stallreq, 1);
    chk({nm, "_rdata_hold"}, conf_rdata, prev);
    n = 0;
    while (stallreq && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_released"}, stallreq, 0);
    chk({nm, "_rdata"}, conf_rdata, data);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    int n;
    conf_en = 1'b0; conf_we = 4'b0000;
    resp_en = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      chk({nm, "_nostall"}, stallreq, 0);
      n++;
    end while ((exp_q.size() != 0 || axi_en) && n < 300);
    chk({nm, "_queue_empty"}, exp_q.size(), 0);
    chk({nm, "_idle"}, axi_en, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int en_cycles;
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
    en_cycles = 0;
  end

  initial begin
    int en_cycles;
    vecs[0] = '{4'hF, 32'hBFAF_F000, 32'h0000_0011, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{4'hF, 32'hBFAF_F004, 32'h0000_0022, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{4'hF, 32'hBFAF_F008, 32'h0000_0033, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{4'h2, 32'hBFD0_F001, 32'h0000_AB00, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{4'hF, 32'hBFAF_F100, 32'h0000_00A1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{4'hF, 32'hBFAF_F104, 32'h0000_00A2, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{4'hF, 32'hBFAF_F108, 32'h0000_00A3, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{4'hF, 32'hBFAF_F10C, 32'h0000_00A4, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{4'hF, 32'hBFAF_F110, 32'h0000_00A5, 1'b0, 1'b0, 1'b1};

    reset = 1'b1;
    conf_en = 1'b0; conf_we = 4'b0000; conf_addr = '0; conf_wdata = '0;
    @(negedge clk);
    chk("rst_axi_en", axi_en, 0);
    chk("rst_axi_wsel", axi_wsel, 0);
    chk("rst_axi_addr", axi_addr, 0);
    chk("rst_axi_wdata", axi_wdata, 0);
    chk("rst_conf_rdata", conf_rdata, 0);
    chk("rst_stallreq", stallreq, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].drain_first) drain($sformatf("vec%0d_pre", i));
      resp_en = vecs[i].resp_en;
      apply_store(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].exp_stall,
                  $sformatf("vec%0d", i));
    end
    drain("table");

    // Two queued stores, then two loads back to back; stores must reach AXI first.
    resp_en = 1'b1;
    apply_store(4'hF, 32'hBFAF_F020, 32'h0000_0055, 1'b0, "ld_st0");
    apply_store(4'hF, 32'hBFAF_F024, 32'h0000_0066, 1'b0, "ld_st1");
    do_load(32'hBFAF_F010, 32'hDEAD_BEEF, 32'h0, "load0");
    do_load(32'hBFAF_F014, 32'hCAFE_F00D, 32'hDEAD_BEEF, "load1");
    conf_en = 1'b0; conf_we = 4'b0000;
    repeat (5) @(negedge clk);
    chk("rdata_hold_idle", conf_rdata, 32'hCAFE_F00D);
    chk("idle_nostall", stallreq, 0);
    drain("loads");

    // Push in the same cycle as a WRITE pop: count must stay 2 (two more fit, third stalls).
    resp_en = 1'b0;
    apply_store(4'hF, 32'hBFAF_F200, 32'h0000_0A0A, 1'b0, "pp_a");
    apply_store(4'hF, 32'hBFAF_F204, 32'h0000_0B0B, 1'b0, "pp_b");
    conf_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reload = 1'b1;
    apply_store(4'hF, 32'hBFAF_F208, 32'h0000_0C0C, 1'b0, "pp_c");
    reload = 1'b0;
    apply_store(4'hF, 32'hBFAF_F20C, 32'h0000_0D0D, 1'b0, "pp_d");
    apply_store(4'hF, 32'hBFAF_F210, 32'h0000_0E0E, 1'b0, "pp_e");
    apply_store(4'hF, 32'hBFAF_F214, 32'h0000_0F0F, 1'b1, "pp_f");
    drain("popush");

    // Reset in the middle of a WRITE with three entries queued.
    resp_en = 1'b0;
    apply_store(4'hF, 32'hBFAF_F300, 32'h0000_1111, 1'b0, "rs_x");
    apply_store(4'hF, 32'hBFAF_F304, 32'h0000_2222, 1'b0, "rs_y");
    apply_store(4'hF, 32'hBFAF_F308, 32'h0000_3333, 1'b0, "rs_z");
    conf_en = 1'b0; conf_we = 4'b0000;
    @(negedge clk);
    chk("rs_in_write", axi_en, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("rs_async_axi_en", axi_en, 0);
    chk("rs_async_wsel", axi_wsel, 0);
    chk("rs_async_addr", axi_addr, 0);
    chk("rs_async_wdata", axi_wdata, 0);
    chk("rs_async_rdata", conf_rdata, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    resp_en = 1'b1;
    en_cycles = 0;
    repeat (20) begin
      @(negedge clk);
      if (axi_en) en_cycles++;
    end
    chk("rs_no_req_after", en_cycles, 0);
    chk("rs_nostall", stallreq, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
